// File: rtl/vedic_mul_seq_8x8_if.sv
// Handshake/operand bundle for the sequential 8x8 Vedic multiplier.
// master: operand source + result consumer; slave: the multiplier.
interface vedic_mul_seq_8x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/vedic_mul_seq_8x8.sv
// Unsigned 8x8 multiplier that time-shares one 4x4 Vedic multiplier over
// four nibble-pair steps, with valid/ready handshakes on operands and result.

// 2x2 Vedic (Urdhva Tiryagbhyam) cell.
module vedic_2_x_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] q
);
    logic t1, t2, t3, c1;

    assign t1   = a[1] & b[0];
    assign t2   = a[0] & b[1];
    assign t3   = a[1] & b[1];
    assign c1   = t1 & t2;
    assign q[0] = a[0] & b[0];
    assign q[1] = t1 ^ t2;
    assign q[2] = t3 ^ c1;
    assign q[3] = t3 & c1;
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells.
module vedic_4_x_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] q
);
    logic [3:0] q0, q1, q2, q3;

    vedic_2_x_2 u_ll (.a(a[1:0]), .b(b[1:0]), .q(q0));
    vedic_2_x_2 u_hl (.a(a[3:2]), .b(b[1:0]), .q(q1));
    vedic_2_x_2 u_lh (.a(a[1:0]), .b(b[3:2]), .q(q2));
    vedic_2_x_2 u_hh (.a(a[3:2]), .b(b[3:2]), .q(q3));

    assign q = {4'b0000, q0}
             + {2'b00, q1, 2'b00}
             + {2'b00, q2, 2'b00}
             + {q3, 4'b0000};
endmodule

module vedic_mul_seq_8x8 #(
    parameter int BYPASS_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vedic_mul_seq_8x8_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [7:0]  a_r, b_r;
    logic [15:0] acc;
    logic [15:0] p_r;

    logic [3:0]  mul_a, mul_b;
    logic [7:0]  pp8;
    logic [15:0] pp_shift;
    logic [15:0] acc_sum;
    logic        accept;
    logic        bypass_hit;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign bypass_hit = (BYPASS_ZERO != 0) && ((bus.a == 8'h00) || (bus.b == 8'h00));

    // Select the nibble pair and shift amount for the current step.
    always_comb begin
        mul_a    = a_r[3:0];
        mul_b    = b_r[3:0];
        pp_shift = '0;
        case (step)
            2'd0: begin
                mul_a    = a_r[3:0];
                mul_b    = b_r[3:0];
                pp_shift = {8'h00, pp8};
            end
            2'd1: begin
                mul_a    = a_r[7:4];
                mul_b    = b_r[3:0];
                pp_shift = {4'h0, pp8, 4'h0};
            end
            2'd2: begin
                mul_a    = a_r[3:0];
                mul_b    = b_r[7:4];
                pp_shift = {4'h0, pp8, 4'h0};
            end
            default: begin
                mul_a    = a_r[7:4];
                mul_b    = b_r[7:4];
                pp_shift = {pp8, 8'h00};
            end
        endcase
    end

    vedic_4_x_4 u_mul (.a(mul_a), .b(mul_b), .q(pp8));

    assign acc_sum = acc + pp_shift;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = bypass_hit ? DONE : MUL;
                end
            end
            MUL: begin
                if (step == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, partial-product accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            p_r  <= '0;
        end else begin
            if (accept) begin
                a_r  <= bus.a;
                b_r  <= bus.b;
                acc  <= '0;
                step <= '0;
                if (bypass_hit) begin
                    p_r <= '0;
                end
            end else if (state == MUL) begin
                acc  <= acc_sum;
                step <= step + 2'd1;
                if (step == 2'd3) begin
                    p_r <= acc_sum;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.p         = p_r;
endmodule

// File: tb/tb_vedic_mul_seq_8x8.sv
// Directed bench for vedic_mul_seq_8x8: a transaction-level model checks
// every cycle, plus literal expectations for products and latencies.
module tb_vedic_mul_seq_8x8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vedic_mul_seq_8x8_if bus0 ();
    vedic_mul_seq_8x8_if bus1 ();

    vedic_mul_seq_8x8 #(.BYPASS_ZERO(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    vedic_mul_seq_8x8 #(.BYPASS_ZERO(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic        iv   [2];
    logic        ordy [2];
    logic [7:0]  av   [2];
    logic [7:0]  bv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        bsy  [2];
    logic [15:0] pv   [2];
    int          acc_cyc [2];
    bit          byp  [2];

    assign bus0.in_valid  = iv[0];
    assign bus0.out_ready = ordy[0];
    assign bus0.a         = av[0];
    assign bus0.b         = bv[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.out_ready = ordy[1];
    assign bus1.a         = av[1];
    assign bus1.b         = bv[1];
    assign ir[0]  = bus0.in_ready;
    assign ov[0]  = bus0.out_valid;
    assign bsy[0] = bus0.busy;
    assign pv[0]  = bus0.p;
    assign ir[1]  = bus1.in_ready;
    assign ov[1]  = bus1.out_valid;
    assign bsy[1] = bus1.busy;
    assign pv[1]  = bus1.p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: a job is outstanding from acceptance until the
    // result is taken; the result shows up `lat` edges after acceptance.
    bit          m_pend [2];
    int          m_cnt  [2];
    int          m_lat  [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_last [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pend[k] = 1'b0;
                m_cnt[k]  = 0;
                m_lat[k]  = 0;
                m_prod[k] = '0;
                m_last[k] = '0;
            end else if (!m_pend[k]) begin
                if (iv[k]) begin
                    m_pend[k] = 1'b1;
                    m_cnt[k]  = 0;
                    m_prod[k] = 16'(av[k]) * 16'(bv[k]);
                    m_lat[k]  = (byp[k] && (av[k] == 0 || bv[k] == 0)) ? 0 : 4;
                end
            end else if (m_cnt[k] >= m_lat[k]) begin
                if (ordy[k]) begin
                    m_pend[k] = 1'b0;
                    m_last[k] = m_prod[k];
                end
            end else begin
                m_cnt[k]++;
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                automatic bit e_valid = m_pend[k] && (m_cnt[k] >= m_lat[k]);
                chk($sformatf("mdl_in_ready%0d", k), 32'(ir[k]), 32'(!m_pend[k]));
                chk($sformatf("mdl_out_valid%0d", k), 32'(ov[k]), 32'(e_valid));
                chk($sformatf("mdl_busy%0d", k), 32'(bsy[k]), 32'(m_pend[k]));
                chk($sformatf("mdl_p%0d", k), 32'(pv[k]), 32'(e_valid ? m_prod[k] : m_last[k]));
            end
        end
    end

    task automatic start(input int k, input logic [7:0] a, input logic [7:0] b);
        iv[k] = 1'b1;
        av[k] = a;
        bv[k] = b;
    endtask

    // Called at a stable point; returns 1ns after the accepting edge.
    task automatic wait_accept(input int k, input string name);
        int n = 0;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            chk({name, "_accept_timeout"}, 32'(ir[k]), 32'd1);
        end
        @(posedge clk);
        #1;
        acc_cyc[k] = cyc;
        iv[k] = 1'b0;
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
    endtask

    // Waits for out_valid, scrambling a/b every cycle; checks latency and p.
    task automatic wait_result(input int k, input logic [15:0] exp, input int exp_lat, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (ov[k] || n >= 40) break;
            chk({name, "_busy_between"}, 32'({ir[k], bsy[k]}), 32'b01);
            if (!iv[k]) begin
                av[k] = 8'($urandom);
                bv[k] = 8'($urandom);
            end
            n++;
        end
        chk({name, "_out_valid"}, 32'(ov[k]), 32'd1);
        chk({name, "_latency"}, 32'(cyc - acc_cyc[k]), 32'(exp_lat));
        chk({name, "_p"}, 32'(pv[k]), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, take_cyc, rel_cyc;
        byp[0] = 1'b1;
        byp[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; av[k] = '0; bv[k] = '0; acc_cyc[k] = 0;
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", 32'(ir[k]), 32'd1);
            chk("reset_out_valid", 32'(ov[k]), 32'd0);
            chk("reset_busy", 32'(bsy[k]), 32'd0);
            chk("reset_p", 32'(pv[k]), 32'd0);
        end

        // First operation right out of reset: accepted at the first edge.
        start(0, 8'h12, 8'h34);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_accept(0, "t1");
        chk("t1_first_edge", 32'(acc_cyc[0]), 32'(rel_cyc + 1));
        wait_result(0, 16'h03A8, 4, "t1");
        @(negedge clk);

        // Back-to-back issue with out_ready held high.
        start(0, 8'hFF, 8'hFF);
        wait_accept(0, "t2a");
        c1 = acc_cyc[0];
        wait_result(0, 16'hFE01, 4, "t2a");
        start(0, 8'hA5, 8'h3C);
        wait_accept(0, "t2b");
        c2 = acc_cyc[0];
        chk("t2_issue_interval", 32'(c2 - c1), 32'd6);
        wait_result(0, 16'h26AC, 4, "t2b");
        @(negedge clk);

        // Zero operand: bypassed on dut0, full sequence on dut1.
        start(0, 8'h00, 8'h7B);
        wait_accept(0, "t3byp");
        wait_result(0, 16'h0000, 0, "t3byp");
        @(negedge clk);
        start(1, 8'h00, 8'h7B);
        wait_accept(1, "t3nobyp");
        wait_result(1, 16'h0000, 4, "t3nobyp");
        @(negedge clk);

        // Backpressure with a new pair already waiting.
        ordy[0] = 1'b0;
        start(0, 8'h0F, 8'h10);
        wait_accept(0, "t4");
        wait_result(0, 16'h00F0, 4, "t4");
        start(0, 8'h01, 8'h01);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(ov[0]), 32'd1);
            chk("t4_hold_p", 32'(pv[0]), 32'h00F0);
            chk("t4_hold_in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        take_cyc = cyc + 1;
        wait_accept(0, "t4b");
        chk("t4_accept_after_take", 32'(acc_cyc[0]), 32'(take_cyc + 1));
        wait_result(0, 16'h0001, 4, "t4b");
        @(negedge clk);

        // Operands scrambled every cycle during MUL.
        start(0, 8'h9C, 8'h2B);
        wait_accept(0, "t5");
        wait_result(0, 16'h1A34, 4, "t5");
        @(negedge clk);

        // Asynchronous reset during step 2.
        start(0, 8'h77, 8'h88);
        wait_accept(0, "t6a");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(ov[0]), 32'd0);
        chk("t6_rst_p", 32'(pv[0]), 32'd0);
        chk("t6_rst_busy", 32'(bsy[0]), 32'd0);
        chk("t6_rst_in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start(0, 8'h77, 8'h88);
        wait_accept(0, "t6b");
        wait_result(0, 16'h3F38, 4, "t6b");
        @(negedge clk);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
